i2s_tx_serfifo: RTL and testbench
=================================

Name: i2s_tx_serfifo

Overview:
Single-clock transmit sample buffer and serializer for the I2S transmitter. It accepts parallel samples from the register/APB side and drives MSB-first serial data, one bit per `shift_en` strobe from the SCK enable generator. It generalises the earlier TX FIFO in four ways: parametrised depth and channel count, 16/24/32-bit frame modes, channel-aligned start, and level, almost-empty, underflow and overflow reporting.

Parameters:
- WIDTH, 32: sample word width; must be >= 32 so every frame mode fits.
- DEPTH, 8: number of FIFO entries; must be a power of 2 and >= CHANNELS.
- CHANNELS, 2: words per audio frame (2 = stereo L/R); must be >= 2.
- AE_THRESH, 2: `almost_empty` asserts when level <= AE_THRESH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push `din` this cycle.
- din  in  WIDTH  sample, LSB-aligned.
- shift_en  in  1  one-cycle serial-bit strobe.
- OP  in  OP_t  control: `frame_size`, `mute`, `stop`.
- flush  in  1  synchronous FIFO clear.
- err_clr  in  1  clears the sticky error flags.
- sd  out  1  serial data.
- ch  out  $clog2(CHANNELS)  channel of the word currently on `sd`.
- word_start  out  1  `sd` is showing the MSB of a word.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(DEPTH)+1  number of stored words.
- underflow  out  1  sticky: a word slot found the FIFO empty.
- overflow  out  1  sticky: a write was rejected because the FIFO was full.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - pointers and level go to 0; state = IDLE.
  - sd=0, ch=0, word_start=0, full=0, empty=1, almost_empty=1, underflow=0, overflow=0.
  - Memory contents are not reset.
- Frame length: maxp = 15, 23 or 31 for f16bits, f24bits, f32bits.
  - Bits [maxp:0] of the word are sent MSB first; upper bits are ignored.
  - `frame_size` is sampled only at word load; a mid-word change takes effect at the next word.
- Write path:
  - A write is accepted when wr_en=1 and full=0; it increments level on the next cycle.
  - wr_en=1 with full=1 drops the data and sets `overflow`.
  - A simultaneous accepted write and pop leaves level unchanged.
  - full, empty, almost_empty and level are registered and exact; there is no synchronizer lag.
- State machine:
  - IDLE: sd=0. Goes to WAIT when stop=0.
  - WAIT: waits until level >= CHANNELS and shift_en=1. In that cycle it pops one word into the shift register, sets bitcnt=maxp, ch=0, and goes to SHIFT. The first MSB appears on sd the next cycle.
  - SHIFT, on shift_en with bitcnt>0: shift left by one and decrement bitcnt.
  - SHIFT, on shift_en with bitcnt=0 (word boundary): ch <= (ch+1) mod CHANNELS, bitcnt <= maxp, and:
    - if FIFO is non-empty, pop and load the next word;
    - if FIFO is empty, load all-zero, set `underflow`, and stay in SHIFT so channel alignment is kept.
  - shift_en=0: everything holds.
- Outputs during SHIFT:
  - sd = bit maxp of the shift register, forced to 0 while mute=1. Shifting and popping continue normally under mute.
  - word_start=1 when bitcnt=maxp in SHIFT.
- Stop: stop=1 forces IDLE on the next edge from any state.
  - sd=0, ch=0 and the shift register is cleared.
  - FIFO contents are kept, and a partially sent word is discarded.
- Flush: flush=1 zeroes the pointers and level, and a write in the same cycle is ignored.
  - If flush=1 and state=SHIFT, the machine returns to WAIT.
- Sticky flags: err_clr=1 clears underflow and overflow. If a new error event occurs in the same cycle, setting wins.
- Pointers: $clog2(DEPTH)-bit addresses that wrap at DEPTH; level is kept as a separate counter.

Decomposition:
- ctrl_pkg:
  - extend frame_t with f16bits, f24bits, f32bits; OP_t keeps frame_size, mute, stop.
  - add function frame_maxp(frame_t) returning int.
  - add enum txser_state_t {IDLE, WAIT, SHIFT}.
- Sub-module sync_fifo (single-clock circular buffer with full/empty/level and overflow pulse), instantiated once.
- The serializer FSM stays in the top module.

Test Plan:
- Reset with DEPTH=8: after reset, empty=1, almost_empty=1, level=0, sd=0, full=0, and both sticky flags are 0.
- f16bits order: write 32'h0000_A5C3 then 32'h0000_FFFF, stop=0, continuous shift_en.
  - After the load cycle, sd carries 1010010111000011 with ch=0, then sixteen 1s with ch=1.
  - word_start pulses at each MSB.
- f24bits: write 32'h00_800001 x2. Each word occupies 24 strobes; sd is 1, twenty-two 0s, then 1.
- Underflow: write 2 words (f16bits) and let them drain.
  - The third slot is sixteen 0s with ch=0 and underflow=1.
  - A write then loads at the next boundary.
  - err_clr clears underflow.
- Overflow and wrap: with stop=1, write 9 words.
  - full=1 after 8 writes; the 9th is dropped, overflow=1, level=8.
  - After a drain, word 8 is followed by the write at address 0 after wrap.
- Stop and mute: assert mute mid-word and check sd=0 while level keeps dropping.
  - Assert stop mid-word: next cycle IDLE, ch=0, sd=0, level unchanged.
  - Release stop: transmission restarts at the next word with ch=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S transmit path: frame modes, the
// register-side control word and the serializer state encoding.
package ctrl_pkg;

  typedef enum logic [1:0] {
    f16bits = 2'd0,
    f24bits = 2'd1,
    f32bits = 2'd2
  } frame_t;

  typedef struct packed {
    frame_t frame_size;
    logic   mute;
    logic   stop;
  } OP_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } txser_state_t;

  // Index of the MSB that goes out first for a given frame mode.
  function automatic int frame_maxp(input frame_t f);
    case (f)
      f16bits: return 15;
      f24bits: return 23;
      default: return 31;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer with registered, exact full/empty/level flags.
// The read port is fall-through: dout_o always shows the oldest entry.
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic             almostEmpty_q;
  logic             push;
  logic             pop;

  // A flush outranks any write or read issued in the same cycle.
  assign push       = wr_en_i && !full_q && !flush_i;
  assign pop        = rd_en_i && !empty_q && !flush_i;
  assign overflow_o = wr_en_i && full_q;
  assign dout_o     = mem[rdPtr_q];

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = almostEmpty_q;
  assign level_o        = level_q;

  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  // Pointers and status flags, all derived from the next level so they are exact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostEmpty_q <= 1'b1;
    end else begin
      if (flush_i) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + 1'b1;
        if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
      level_q       <= level_d;
      full_q        <= (level_d == DEPTH_L);
      empty_q       <= (level_d == '0);
      almostEmpty_q <= (level_d <= AE_L);
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/i2s_tx_serfifo.sv
// I2S transmit buffer and MSB-first serializer. Words are buffered in a
// sync_fifo and shifted out one bit per shift_en strobe, channel-aligned.
module i2s_tx_serfifo
  import ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            din,
  input  logic                        shift_en,
  input  OP_t                         OP,
  input  logic                        flush,
  input  logic                        err_clr,
  output logic                        sd,
  output logic [$clog2(CHANNELS)-1:0] ch,
  output logic                        word_start,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        underflow,
  output logic                        overflow
);

  localparam int CW = $clog2(CHANNELS);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] CHAN_L  = LW'(CHANNELS);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  txser_state_t     state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [4:0]       bitCnt_q, bitCnt_d;
  logic [4:0]       maxp_q,   maxp_d;
  logic [CW-1:0]    ch_q,     ch_d;
  logic             underflow_q;
  logic             overflow_q;
  logic [4:0]       loadMaxp;
  logic             pop;
  logic             underEvt;
  logic             fifoOvf;
  logic [WIDTH-1:0] fifoDout;

  sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AE_THRESH (AE_THRESH)
  ) u_fifo (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .wr_en_i        (wr_en),
    .din_i          (din),
    .rd_en_i        (pop),
    .dout_o         (fifoDout),
    .full_o         (full),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
    .level_o        (level),
    .overflow_o     (fifoOvf)
  );

  assign loadMaxp   = 5'(frame_maxp(OP.frame_size));
  assign sd         = (state_q == SHIFT) && !OP.mute && shreg_q[maxp_q];
  assign word_start = (state_q == SHIFT) && (bitCnt_q == maxp_q);
  assign ch         = ch_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;

  // Serializer next state: stop beats flush, flush beats normal shifting.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitCnt_d = bitCnt_q;
    maxp_d   = maxp_q;
    ch_d     = ch_q;
    pop      = 1'b0;
    underEvt = 1'b0;
    if (OP.stop) begin
      state_d  = IDLE;
      shreg_d  = '0;
      bitCnt_d = '0;
      ch_d     = '0;
    end else if (flush && state_q == SHIFT) begin
      state_d = WAIT;
      ch_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (!flush && shift_en && level >= CHAN_L) begin
            pop      = 1'b1;
            shreg_d  = fifoDout;
            bitCnt_d = loadMaxp;
            maxp_d   = loadMaxp;
            ch_d     = '0;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (bitCnt_q != 5'd0) begin
              shreg_d  = shreg_q << 1;
              bitCnt_d = bitCnt_q - 5'd1;
            end else begin
              ch_d     = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
              bitCnt_d = loadMaxp;
              maxp_d   = loadMaxp;
              if (!empty) begin
                pop     = 1'b1;
                shreg_d = fifoDout;
              end else begin
                shreg_d  = '0;
                underEvt = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Serializer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitCnt_q <= '0;
      maxp_q   <= 5'd15;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitCnt_q <= bitCnt_d;
      maxp_q   <= maxp_d;
      ch_q     <= ch_d;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (underEvt)     underflow_q <= 1'b1;
      else if (err_clr) underflow_q <= 1'b0;
      if (fifoOvf)      overflow_q  <= 1'b1;
      else if (err_clr) overflow_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serfifo.sv
// Scoreboard bench for i2s_tx_serfifo: expected serial bits are queued by
// the stimulus, a negedge monitor compares them; status flags are checked directly.
module tb_i2s_tx_serfifo;
  import ctrl_pkg::*;

  typedef struct packed {
    logic sd;
    logic ch;
    logic ws;
  } expBit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] din;
  logic        shift_en;
  OP_t         OP;
  logic        flush;
  logic        err_clr;
  logic        sd;
  logic [0:0]  ch;
  logic        word_start;
  logic        full;
  logic        empty;
  logic        almost_empty;
  logic [3:0]  level;
  logic        underflow;
  logic        overflow;

  expBit_t expQ[$];
  int      checks = 0;
  int      errors = 0;
  int      bitIdx = 0;
  bit      monStarted = 1'b0;

  i2s_tx_serfifo #(
    .WIDTH     (32),
    .DEPTH     (8),
    .CHANNELS  (2),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .shift_en     (shift_en),
    .OP           (OP),
    .flush        (flush),
    .err_clr      (err_clr),
    .sd           (sd),
    .ch           (ch),
    .word_start   (word_start),
    .full         (full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Monitor: once the DUT shows a word MSB, every cycle's bit is popped and compared.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      if (!monStarted && word_start) monStarted = 1'b1;
      if (monStarted) begin
        expBit_t e;
        expBit_t a;
        e = expQ.pop_front();
        a = {sd, ch[0], word_start};
        checks++;
        if (a !== e) begin
          errors++;
          $display("[TB] FAIL serialBit#%0d: sd/ch/ws got %b required %b", bitIdx, a, e);
        end
        bitIdx++;
        if (expQ.size() == 0) monStarted = 1'b0;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    wr_en = 1'b1;
    din   = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w, input int maxp, input int chan);
    for (int i = maxp; i >= 0; i--) begin
      expBit_t e;
      e.sd = w[i];
      e.ch = chan[0];
      e.ws = (i == maxp);
      expQ.push_back(e);
    end
  endtask

  task automatic waitQueue(input int target, input int budget, input string name);
    int n = 0;
    while (expQ.size() > target && n < budget) begin
      tick();
      n++;
    end
    if (expQ.size() > target) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout with %0d bits pending, required %0d", name, expQ.size(), target);
      expQ.delete();
      monStarted = 1'b0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; din = '0; shift_en = 1'b1;
    OP.frame_size = f16bits; OP.mute = 1'b0; OP.stop = 1'b1;
    flush = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstEmpty", 32'(empty), 32'd1);
    checkOutput("rstAlmostEmpty", 32'(almost_empty), 32'd1);
    checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstSd", 32'(sd), 32'd0);
    checkOutput("rstFull", 32'(full), 32'd0);
    checkOutput("rstUnderflow", 32'(underflow), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    checkOutput("rstCh", 32'(ch), 32'd0);

    $display("[TB] f16 order and underflow");
    applyStimulus(32'h0000_A5C3);
    applyStimulus(32'h0000_FFFF);
    checkOutput("f16Level", 32'(level), 32'd2);
    checkOutput("f16AlmostEmpty", 32'(almost_empty), 32'd1);
    pushWord(32'h0000_A5C3, 15, 0);
    pushWord(32'h0000_FFFF, 15, 1);
    pushWord(32'h0000_0000, 15, 0);
    OP.stop = 1'b0;
    waitQueue(8, 400, "f16Reach3rdSlot");
    checkOutput("underflowSet", 32'(underflow), 32'd1);
    applyStimulus(32'h0000_1234);
    pushWord(32'h0000_1234, 15, 1);
    waitQueue(0, 400, "f16Drain");
    OP.stop = 1'b1;
    tick();
    checkOutput("stopSd", 32'(sd), 32'd0);
    checkOutput("stopCh", 32'(ch), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("errClrUnderflow", 32'(underflow), 32'd0);

    $display("[TB] f24 frames");
    OP.frame_size = f24bits;
    applyStimulus(32'h0080_0001);
    applyStimulus(32'h0080_0001);
    pushWord(32'h0080_0001, 23, 0);
    pushWord(32'h0080_0001, 23, 1);
    OP.stop = 1'b0;
    waitQueue(0, 400, "f24Drain");
    OP.stop = 1'b1;
    tick();

    $display("[TB] overflow and wrap");
    OP.frame_size = f16bits;
    err_clr = 1'b1; flush = 1'b1;
    tick();
    err_clr = 1'b0; flush = 1'b0;
    checkOutput("flushLevel", 32'(level), 32'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(32'h5A5A_0000 | (i * 32'h0000_1111));
    checkOutput("ovfFull8", 32'(full), 32'd1);
    checkOutput("ovfLevel8", 32'(level), 32'd8);
    checkOutput("ovfAlmostEmpty8", 32'(almost_empty), 32'd0);
    checkOutput("ovfNotYet", 32'(overflow), 32'd0);
    applyStimulus(32'h5A5A_9999);
    checkOutput("ovfSticky", 32'(overflow), 32'd1);
    checkOutput("ovfLevel9", 32'(level), 32'd8);
    checkOutput("ovfFull9", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) pushWord(i * 32'h0000_1111, 15, (i - 1) % 2);
    OP.stop = 1'b0;
    waitQueue(64, 400, "wrapHalfDrain");
    applyStimulus(32'h0000_ABCD);
    pushWord(32'h0000_ABCD, 15, 0);
    waitQueue(0, 600, "wrapDrain");
    OP.stop = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("errClrOverflow", 32'(overflow), 32'd0);

    $display("[TB] mute and stop");
    applyStimulus(32'h0000_FFFF);
    applyStimulus(32'h0000_FFFF);
    applyStimulus(32'h0000_8001);
    applyStimulus(32'h0000_7FFE);
    OP.stop = 1'b0;
    n = 0;
    while (!word_start && n < 20) begin
      tick();
      n++;
    end
    checkOutput("muteWordStart", 32'(word_start), 32'd1);
    checkOutput("muteLevelLoad", 32'(level), 32'd3);
    repeat (4) tick();
    OP.mute = 1'b1;
    tick();
    checkOutput("muteSd", 32'(sd), 32'd0);
    repeat (13) tick();
    checkOutput("muteLevelDrop", 32'(level), 32'd2);
    checkOutput("muteCh", 32'(ch), 32'd1);
    checkOutput("muteSd2", 32'(sd), 32'd0);
    OP.mute = 1'b0;
    tick();
    checkOutput("unmuteSd", 32'(sd), 32'd1);
    OP.stop = 1'b1;
    tick();
    checkOutput("midStopSd", 32'(sd), 32'd0);
    checkOutput("midStopCh", 32'(ch), 32'd0);
    checkOutput("midStopWs", 32'(word_start), 32'd0);
    checkOutput("midStopLevel", 32'(level), 32'd2);
    tick();
    checkOutput("idleLevelHeld", 32'(level), 32'd2);
    pushWord(32'h0000_8001, 15, 0);
    pushWord(32'h0000_7FFE, 15, 1);
    OP.stop = 1'b0;
    waitQueue(0, 400, "restartDrain");
    OP.stop = 1'b1;
    tick();

    $display("[TB] flush with write");
    applyStimulus(32'h0000_0F0F);
    wr_en = 1'b1; din = 32'h0000_F0F0; flush = 1'b1;
    tick();
    wr_en = 1'b0; flush = 1'b0;
    checkOutput("flushWrLevel", 32'(level), 32'd0);
    checkOutput("flushWrEmpty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
